// File: rtl/ifu_itcm_ctrl.sv
// ifu_itcm_ctrl: IFU fetch responder backed by a single-port ITCM SRAM.
// Fetches are range/alignment checked and answered in order through a 2-entry buffer; loader writes win the SRAM port.
module ifu_itcm_ctrl #(
  parameter int PC_SIZE = 32,
  parameter int INSTR_SIZE = 32,
  parameter int ADDR_W = 14,
  parameter logic [PC_SIZE-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic                  ifu_rsp_err,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [PC_SIZE-1:0]    ld_addr,
  input  logic [INSTR_SIZE-1:0] ld_wdata,
  output logic                  ld_err,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [INSTR_SIZE-1:0] ram_wdata,
  input  logic [INSTR_SIZE-1:0] ram_rdata
);
  localparam logic [PC_SIZE:0] LO = {1'b0, BASE_ADDR};
  localparam logic [PC_SIZE:0] HI = LO + ((PC_SIZE+1)'(1) << (ADDR_W + 2));

  function automatic logic addr_ok(input logic [PC_SIZE-1:0] a);
    return ({1'b0, a} >= LO) && ({1'b0, a} < HI) && (a[1:0] == 2'b00);
  endfunction

  logic                  inflight_q, infl_err_q, ld_err_q, wptr_q, rptr_q;
  logic [1:0]            cnt_q;
  logic                  buf_err_q [2];
  logic [INSTR_SIZE-1:0] buf_instr_q [2];
  logic [1:0]            occ;
  logic                  req_ok, ld_ok, req_hsk, buf_nz, push, pop, byp_err;
  logic [INSTR_SIZE-1:0] byp_instr;

  assign occ = cnt_q + {1'b0, inflight_q};
  assign req_ok = addr_ok(ifu_req_pc);
  assign ld_ok = addr_ok(ld_addr);
  // Ready comes only from registered occupancy and the loader, never from rsp_ready.
  assign ifu_req_ready = ~ld_valid & (occ < 2'd2);
  assign req_hsk = ifu_req_valid & ifu_req_ready;
  assign ram_cs = (ld_valid & ld_ok) | (req_hsk & req_ok);
  assign ram_we = ld_valid & ld_ok;
  assign ram_addr = ld_valid ? ld_addr[ADDR_W+1:2] : ifu_req_pc[ADDR_W+1:2];
  assign ram_wdata = ld_wdata;
  assign ld_ready = 1'b1;
  assign ld_err = ld_err_q;
  // Bypass value is forced to zero when idle so the outputs read zero out of reset.
  assign byp_err = inflight_q & infl_err_q;
  assign byp_instr = (inflight_q & ~infl_err_q) ? ram_rdata : '0;
  assign buf_nz = cnt_q != 2'd0;
  assign ifu_rsp_valid = buf_nz | inflight_q;
  assign ifu_rsp_err = buf_nz ? buf_err_q[rptr_q] : byp_err;
  assign ifu_rsp_instr = buf_nz ? buf_instr_q[rptr_q] : byp_instr;
  assign push = inflight_q & (buf_nz | ~ifu_rsp_ready);
  assign pop = buf_nz & ifu_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      infl_err_q <= 1'b0;
      ld_err_q <= 1'b0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      inflight_q <= req_hsk;
      if (req_hsk) infl_err_q <= ~req_ok;
      ld_err_q <= ld_valid & ~ld_ok;
      if (push) wptr_q <= ~wptr_q;
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_err_q[wptr_q] <= byp_err;
      buf_instr_q[wptr_q] <= byp_instr;
    end
  end
endmodule

// File: doc/ifu_itcm_ctrl.md
Name: ifu_itcm_ctrl

Overview:
- Responder end of the IFU instruction-fetch request/response channel; serves the fetch initiator from a single-port synchronous-read ITCM SRAM.
- Accepts one fetch request per cycle, performs address range and alignment checks, issues the SRAM read, and returns instruction or error through a 2-entry response buffer.
- A loader write port (program load/debug) shares the SRAM port with priority over fetch.

Parameters:
- PC_SIZE, 32, fetch address width
- INSTR_SIZE, 32, instruction/data width
- ADDR_W, 14, SRAM word-address width (ITCM size = 4*2^ADDR_W bytes)
- BASE_ADDR, 32'h8000_0000, ITCM byte base address (aligned to ITCM size)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  fetch request valid
- ifu_req_ready  out  1  fetch request ready
- ifu_req_pc  in  PC_SIZE  fetch byte address
- ifu_rsp_valid  out  1  response valid
- ifu_rsp_ready  in  1  response ready
- ifu_rsp_err  out  1  response error (range/alignment)
- ifu_rsp_instr  out  INSTR_SIZE  fetched instruction
- ld_valid  in  1  loader write valid
- ld_ready  out  1  loader write ready (constant 1)
- ld_addr  in  PC_SIZE  loader byte address
- ld_wdata  in  INSTR_SIZE  loader write data
- ld_err  out  1  registered one-cycle pulse: the previous loader write was out of range or misaligned, and was dropped
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  ADDR_W  SRAM word address
- ram_wdata  out  INSTR_SIZE  SRAM write data
- ram_rdata  in  INSTR_SIZE  SRAM read data, valid the cycle after a read

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset state: in-flight flag, buffer count, pointers and ld_err cleared; outputs ifu_rsp_valid=0, ifu_rsp_err=0, ifu_rsp_instr=0, ram_cs=0, ram_we=0. After reset ifu_req_ready=1 while ld_valid=0.
- Address check: in_range = (pc >= BASE_ADDR) & (pc < BASE_ADDR + 4*2^ADDR_W); aligned = (pc[1:0]==0). ram_addr = pc[ADDR_W+1:2].
- Occupancy:
  - occ = buffer count (0..2) + inflight (0/1). Both are registers.
  - ifu_req_ready = ~ld_valid & (occ < 2).
  - ifu_req_ready must never depend combinationally on ifu_rsp_ready or ifu_req_valid. The initiator gates its rsp_ready with req_ready.
- Fetch accept (req hsk, cycle N):
  - Good address: ram_cs=1, ram_we=0. Set inflight with err=0.
  - Bad address: no SRAM access. Set inflight with err=1.
- Cycle N+1 (inflight): the response is {err, err ? 0 : ram_rdata}.
  - Buffer empty: presented directly on the rsp outputs (bypass, 1-cycle latency).
  - Buffer not empty, or ifu_rsp_ready=0: written to the buffer tail.
  - inflight clears unless a new request is accepted in the same cycle.
- Buffer: 2-entry FIFO of {err, instr}. ifu_rsp_valid = (count!=0) | inflight. The output is the head entry when count!=0, otherwise the bypass value.
- Response rules: held stable while valid & ~ready. Push and pop in the same cycle leave count unchanged. Back-to-back fetch (a new req accepted in the same cycle as a rsp handshake) sustains 1 instruction/cycle.
- Loader:
  - ld_valid has priority: it forces ifu_req_ready=0. An in-flight read still completes, because its data was captured from the read issued last cycle.
  - Good loader address: ram_cs=1, ram_we=1, ram_wdata=ld_wdata in the same cycle.
  - Bad loader address: write dropped; ld_err=1 on the next cycle.
- Flush: no port; the initiator drops responses by holding rsp_ready=1. All responses are returned in order; none are discarded internally.
- Reset mid-operation: all in-flight and buffered responses are lost; no response is emitted after reset.

Test Plan:
- Reset, ld_valid=0 -> ifu_req_ready=1, ifu_rsp_valid=0, ram_cs=0. Loader writes 0x00000013 to 0x80000000 -> ram_we=1, ram_addr=0. Fetch 0x80000000 -> cycle+1: rsp_valid=1, instr=0x00000013, err=0.
- Stream of 8 sequential fetches from 0x80000000 with rsp_ready=1 -> 8 responses on 8 consecutive cycles, correct data order, ifu_req_ready never drops.
- rsp_ready=0 after two fetches -> ifu_req_ready=0 once occ=2. Data are held stable. Release -> both returned in order, then ready=1.
- Fetch 0x80010000 (ADDR_W=14, out of range) and 0x80000002 (misaligned) -> ram_cs=0, rsp err=1, instr=0, 1-cycle latency each.
- ld_valid asserted the same cycle as a fetch request -> req not accepted (ready=0), write performed. The previous in-flight fetch still returns correct data.
- Assert rst while the buffer holds 2 entries -> outputs return to reset values immediately; no stale response appears after reset release.
